// File: rtl/conv_encoder_framer_if.sv
// Handshake and status bundle between the bit source and the convolutional encoder framer.
// master drives the information stream and start; slave is the encoder.
interface conv_encoder_framer_if;
    logic       start;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       sym_valid;
    logic [1:0] sym;
    logic       enc_enable;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    modport master (
        output start, in_valid, in_bit,
        input  in_ready, sym_valid, sym, enc_enable, busy, frame_done, underrun
    );

    modport slave (
        input  start, in_valid, in_bit,
        output in_ready, sym_valid, sym, enc_enable, busy, frame_done, underrun
    );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=4 convolutional encoder with frame control and zero-tail termination.
// Emits one 2-bit symbol per accepted bit plus 3 tail symbols, and the decoder enable window.
module conv_encoder_framer #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter logic [3:0]  G0        = 4'b1101,
    parameter logic [3:0]  G1        = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_encoder_framer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       s;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       tail_cnt;
    logic [1:0]       sym_q;
    logic             sym_valid_q;
    logic             enc_enable_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             underrun_q;

    // Encoder input is the data bit in DATA and a forced zero during the tail.
    logic       enc_bit_c;
    logic [3:0] u_c;
    logic [1:0] sym_c;

    assign enc_bit_c = (state == DATA) ? bus.in_bit : 1'b0;
    assign u_c       = {enc_bit_c, s};
    assign sym_c     = {^(u_c & G0), ^(u_c & G1)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            s            <= 3'b000;
            bit_cnt      <= '0;
            tail_cnt     <= 2'd0;
            sym_q        <= 2'b00;
            sym_valid_q  <= 1'b0;
            enc_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sym_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= DATA;
                        busy_q     <= 1'b1;
                        s          <= 3'b000;
                        bit_cnt    <= '0;
                        underrun_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (bus.in_valid) begin
                        sym_q        <= sym_c;
                        sym_valid_q  <= 1'b1;
                        enc_enable_q <= 1'b1;
                        s            <= {enc_bit_c, s[2:1]};
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_CNT) begin
                            state    <= TAIL;
                            tail_cnt <= 2'd0;
                        end
                    end else begin
                        underrun_q <= 1'b1;
                    end
                end
                TAIL: begin
                    // Three tail symbols, then one closing cycle that lands in IDLE with frame_done.
                    if (tail_cnt == 2'd3) begin
                        state        <= IDLE;
                        busy_q       <= 1'b0;
                        enc_enable_q <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        sym_q       <= sym_c;
                        sym_valid_q <= 1'b1;
                        s           <= {enc_bit_c, s[2:1]};
                        tail_cnt    <= tail_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == DATA);
    assign bus.sym_valid  = sym_valid_q;
    assign bus.sym        = sym_q;
    assign bus.enc_enable = enc_enable_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer with FRAME_LEN=4 and the default polynomials.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_conv_encoder_framer;

    localparam int unsigned FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_encoder_framer_if bus ();

    conv_encoder_framer #(
        .FRAME_LEN(FRAME_LEN),
        .G0       (4'b1101),
        .G1       (4'b1111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // exp packs {in_ready, sym_valid, sym[1:0], enc_enable, busy, frame_done, underrun}
    typedef struct {
        logic       start;
        logic       iv;
        logic       ib;
        logic [7:0] exp;
    } vec_t;

    vec_t golden [9];
    vec_t stall  [11];
    vec_t idle_row;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] last_sym = 2'b00;

    function automatic vec_t mk(input logic st, input logic iv, input logic ib,
                                input logic rdy, input logic sv, input logic [1:0] sy,
                                input logic en, input logic bz, input logic dn, input logic ur);
        vec_t v;
        v.start = st;
        v.iv    = iv;
        v.ib    = ib;
        v.exp   = {rdy, sv, sy, en, bz, dn, ur};
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.in_ready, bus.sym_valid, bus.sym, bus.enc_enable,
                bus.busy, bus.frame_done, bus.underrun};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (rdy,sv,sym,en,busy,done,ur)", name, act, exp);
        end
    endtask

    // Between symbols the expected sym is the last symbol the bench expected to see.
    task automatic apply(input vec_t v, input logic force_start, input string name, input int idx);
        logic [7:0] e;
        bus.start    = v.start | force_start;
        bus.in_valid = v.iv;
        bus.in_bit   = v.ib;
        @(negedge clk);
        e = v.exp;
        if (e[6]) last_sym = e[5:4];
        else      e[5:4]   = last_sym;
        check($sformatf("%s[%0d]", name, idx), outs(), e);
    endtask

    task automatic run_golden(input string name, input logic force_mid_start);
        for (int i = 0; i < 9; i++)
            apply(golden[i], force_mid_start && (i >= 1) && (i <= 7), name, i);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;

        //                 st iv ib  rdy sv sym    en bz dn ur
        golden[0] = mk(1, 0, 0,  1, 0, 2'b00, 0, 1, 0, 0);
        golden[1] = mk(0, 1, 1,  1, 1, 2'b11, 1, 1, 0, 0);
        golden[2] = mk(0, 1, 0,  1, 1, 2'b11, 1, 1, 0, 0);
        golden[3] = mk(0, 1, 1,  1, 1, 2'b10, 1, 1, 0, 0);
        golden[4] = mk(0, 1, 1,  0, 1, 2'b11, 1, 1, 0, 0);
        golden[5] = mk(0, 0, 0,  0, 1, 2'b10, 1, 1, 0, 0);
        golden[6] = mk(0, 0, 0,  0, 1, 2'b10, 1, 1, 0, 0);
        golden[7] = mk(0, 0, 0,  0, 1, 2'b11, 1, 1, 0, 0);
        golden[8] = mk(0, 0, 0,  0, 0, 2'b00, 0, 0, 1, 0);

        stall[0]  = mk(1, 0, 0,  1, 0, 2'b00, 0, 1, 0, 0);
        stall[1]  = mk(0, 1, 1,  1, 1, 2'b11, 1, 1, 0, 0);
        stall[2]  = mk(0, 1, 0,  1, 1, 2'b11, 1, 1, 0, 0);
        stall[3]  = mk(0, 0, 0,  1, 0, 2'b00, 1, 1, 0, 1);
        stall[4]  = mk(0, 0, 1,  1, 0, 2'b00, 1, 1, 0, 1);
        stall[5]  = mk(0, 1, 1,  1, 1, 2'b10, 1, 1, 0, 1);
        stall[6]  = mk(0, 1, 1,  0, 1, 2'b11, 1, 1, 0, 1);
        stall[7]  = mk(0, 0, 0,  0, 1, 2'b10, 1, 1, 0, 1);
        stall[8]  = mk(0, 0, 0,  0, 1, 2'b10, 1, 1, 0, 1);
        stall[9]  = mk(0, 0, 0,  0, 1, 2'b11, 1, 1, 0, 1);
        stall[10] = mk(0, 0, 0,  0, 0, 2'b00, 0, 0, 1, 1);

        idle_row  = mk(0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 0);

        // Reset held with random inputs: every output stays low.
        for (int i = 0; i < 6; i++) begin
            bus.start    = 1'($urandom);
            bus.in_valid = 1'($urandom);
            bus.in_bit   = 1'($urandom);
            @(negedge clk);
            check($sformatf("reset_hold[%0d]", i), outs(), 8'h00);
        end

        // Out of reset without start: still idle.
        rst       = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_bit   = 1'($urandom);
            @(negedge clk);
            check($sformatf("post_reset_idle[%0d]", i), outs(), 8'h00);
        end

        run_golden("golden", 1'b0);
        check("golden_final_state", 8'(dut.s), 8'h00);
        apply(idle_row, 1'b0, "idle_a", 0);

        for (int i = 0; i < 11; i++) apply(stall[i], 1'b0, "stall", i);

        // Start in the frame_done cycle of the stalled frame; underrun must clear.
        run_golden("b2b_after_stall", 1'b0);
        run_golden("b2b_golden", 1'b0);
        check("b2b_final_state", 8'(dut.s), 8'h00);
        apply(idle_row, 1'b0, "idle_b", 0);

        run_golden("ignored_start", 1'b1);
        apply(idle_row, 1'b0, "idle_c", 0);

        // Asynchronous reset during TAIL, between clock edges.
        for (int i = 0; i < 6; i++) apply(golden[i], 1'b0, "pre_reset", i);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outs", outs(), 8'h00);
        check("async_reset_state", 8'(dut.s), 8'h00);
        last_sym = 2'b00;
        @(negedge clk);
        check("reset_held_outs", outs(), 8'h00);
        rst = 1'b1;

        run_golden("after_reset", 1'b0);
        check("after_reset_final_state", 8'(dut.s), 8'h00);
        apply(idle_row, 1'b0, "idle_d", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_encoder_framer.md
# conv_encoder_framer

Rate-1/2, constraint-length-4 (8-state) convolutional encoder with frame control. It sits directly upstream of the Viterbi decoder. It accepts an information bit stream over a valid/ready handshake and emits one 2-bit coded symbol per accepted bit. Each frame is terminated with 3 zero tail bits so the trellis returns to state 0. It also generates the decoder's `enable` window.

## Interface
Parameters:
- FRAME_LEN, 1024: information bits per frame; legal range 1 to 65535.
- G0, 4'b1101: generator polynomial for sym[1]. Bit 3 taps the current input; bits 2..0 tap s[2..0].
- G1, 4'b1111: generator polynomial for sym[0], same bit mapping as G0.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: single-cycle pulse that begins a frame; sampled only in IDLE.
- in_valid, in, 1: in_bit is valid.
- in_bit, in, 1: information bit.
- in_ready, out, 1: encoder accepts in_bit this cycle.
- sym_valid, out, 1: sym holds a new coded symbol.
- sym, out, 2: coded symbol {c0,c1}; drives the decoder's d_in.
- enc_enable, out, 1: decoder enable window; drives the decoder's enable.
- busy, out, 1: high when the FSM is not in IDLE.
- frame_done, out, 1: one-cycle pulse at the end of a frame.
- underrun, out, 1: sticky flag; set when in_valid is low while in DATA.

## Operation
- Encoder state s[2:0] holds the last three input bits; s[2] is the most recent.
- Per encoded bit b, form u = {b, s}. Then c0 = ^(u & G0), c1 = ^(u & G1), sym <= {c0,c1}, and s <= {b, s[2:1]}.
- FSM states:
  - IDLE: in_ready=0. When start=1, go to DATA and set s=0, bit_cnt=0, underrun=0.
  - DATA: in_ready=1. On each in_valid&&in_ready, encode in_bit and increment bit_cnt. When the accepted bit is number FRAME_LEN, go to TAIL with tail_cnt=0 and drop in_ready the next cycle.
  - TAIL: in_ready=0. Encode b=0 on each of 3 consecutive cycles. After the third, go to IDLE.
- Counters:
  - bit_cnt width is $clog2(FRAME_LEN+1), so there is no wrap within a frame.
  - tail_cnt is 2 bits.
- After the third tail bit, s = 000, which matches the decoder's reset validity of state 0 only.
- Stall: if in_valid=0 in DATA, no symbol is produced, sym_valid=0, and underrun is set and held until the next start. The decoder cannot stall, so underrun indicates a corrupted frame. The encoder still completes the frame once data resumes.
- start while busy is ignored; it does not restart the frame.
- Asynchronous reset mid-frame: all state is cleared, the FSM returns to IDLE, and enc_enable drops immediately.
- Back-to-back frames: start may be asserted in the same cycle frame_done is high. It is honoured on the following cycle, because the FSM reaches IDLE together with frame_done.

## Timing
- Reset values: in_ready=0, sym_valid=0, sym=2'b00, enc_enable=0, busy=0, frame_done=0, underrun=0, s=000.
- All outputs are registered except in_ready, which is a combinational decode of the FSM state.
- Latency: a bit accepted in cycle n produces sym and sym_valid=1 in cycle n+1.
- With continuous in_valid, sym_valid is high for exactly FRAME_LEN+3 consecutive cycles.
- enc_enable:
  - Rises in the same cycle as the first sym_valid of the frame.
  - Stays high through the last tail symbol, including any stall cycles.
  - Falls on the cycle after the last tail symbol, which is the same cycle frame_done pulses.
- Between symbols, sym holds its last value.
- The first start can be accepted 1 cycle after rst deasserts.

## Test plan
- Reset: hold rst=0 with random stimulus on all inputs -> every output stays 0. Release rst -> outputs stay 0 until start.
- Golden vector, FRAME_LEN=4, default polynomials, input 1,0,1,1 continuous:
  - sym sequence is 11, 11, 10, 11, then tail 10, 10, 11.
  - sym_valid is high for 7 cycles, enc_enable is high for the same 7 cycles, and frame_done pulses on the 8th cycle.
  - Final s = 000.
- Stall: FRAME_LEN=4 with in_valid low for 2 cycles after the 2nd bit -> sym_valid gaps for 2 cycles, underrun=1, and the symbol sequence is unchanged from the golden vector.
- Back-to-back frames: assert start in the frame_done cycle, then run the golden input again -> the identical 7-symbol sequence repeats (s was reset to 0), and underrun=0.
- Ignored start and mid-frame reset: pulse start during DATA -> no effect. Pull rst low during TAIL -> enc_enable, busy and sym_valid are 0 immediately, and the next frame encodes correctly from s=0.
- Loopback: FRAME_LEN=1024, 4 frames of random bits into the Viterbi decoder with an error-free channel -> decoded d_out matches the input bits after the decoder's pipeline latency.
